dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_rr_pick.sv | 21 ++
 rtl/dmem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the CPU / I/O data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_IO  = 1'b1
    } req_id_e;

    function automatic logic word_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone request wins; on a tie the requester not granted last wins.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    last_grant_i,
    output req_id_e    grant_o
);

    // Bit 0 is the CPU request, bit 1 the I/O request.
    always_comb begin
        grant_o = REQ_CPU;
        case (req_i)
            2'b01:   grant_o = REQ_CPU;
            2'b10:   grant_o = REQ_IO;
            2'b11:   grant_o = (last_grant_i == REQ_CPU) ? REQ_IO : REQ_CPU;
            default: grant_o = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and I/O requesters onto one data-memory port (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_ALIGN_CHK_EN to skip non-word-aligned accesses and flag them on err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic              err,
    output logic              dm_cs,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout
);

    state_e            state_q, state_d;
    req_id_e           last_grant_q, last_grant_d;
    req_id_e           owner_q, owner_d;
    req_id_e           pick_s;
    logic              any_req_s, sel_wr_s, misaligned_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              wr_q, wr_d, skip_q, skip_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
    logic              cpu_ack_q, cpu_ack_d, io_ack_q, io_ack_d, err_q, err_d;
    logic              dm_cs_q, dm_cs_d, dm_rd_q, dm_rd_d, dm_wr_q, dm_wr_d;

    dmem_rr_pick u_pick (
        .req_i        ({io_req, cpu_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_s)
    );

    assign any_req_s   = cpu_req | io_req;
    assign sel_wr_s    = (pick_s == REQ_IO) ? io_wr    : cpu_wr;
    assign sel_addr_s  = (pick_s == REQ_IO) ? io_addr  : cpu_addr;
    assign sel_wdata_s = (pick_s == REQ_IO) ? io_wdata : cpu_wdata;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign misaligned_s = word_misaligned(sel_addr_s[1:0]);
`else
    assign misaligned_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCESS and RESP each last one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: memory strobes are set up one edge early so they are registered in ACCESS.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        skip_d       = skip_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        io_rdata_d   = io_rdata_q;
        cpu_ack_d    = 1'b0;
        io_ack_d     = 1'b0;
        err_d        = 1'b0;
        dm_cs_d      = 1'b0;
        dm_rd_d      = 1'b0;
        dm_wr_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    last_grant_d = pick_s;
                    owner_d      = pick_s;
                    wr_d         = sel_wr_s;
                    skip_d       = misaligned_s;
                    addr_d       = sel_addr_s;
                    wdata_d      = sel_wdata_s;
                    dm_cs_d      = ~misaligned_s;
                    dm_rd_d      = ~misaligned_s & ~sel_wr_s;
                    dm_wr_d      = ~misaligned_s & sel_wr_s;
                end else begin
                    last_grant_d = last_grant_q;
                end
            end
            ST_ACCESS: begin
                if (!skip_q && !wr_q && owner_q == REQ_CPU) begin
                    cpu_rdata_d = dm_dout;
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
                if (!skip_q && !wr_q && owner_q == REQ_IO) begin
                    io_rdata_d = dm_dout;
                end else begin
                    io_rdata_d = io_rdata_q;
                end
                cpu_ack_d = (owner_q == REQ_CPU);
                io_ack_d  = (owner_q == REQ_IO);
                err_d     = skip_q;
            end
            ST_RESP: begin
                cpu_ack_d = 1'b0;
                io_ack_d  = 1'b0;
            end
            default: begin
                cpu_ack_d = 1'b0;
                io_ack_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_IO;
            owner_q      <= REQ_CPU;
            wr_q         <= 1'b0;
            skip_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
            cpu_ack_q    <= 1'b0;
            io_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            dm_cs_q      <= 1'b0;
            dm_rd_q      <= 1'b0;
            dm_wr_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            skip_q       <= skip_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            io_rdata_q   <= io_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            io_ack_q     <= io_ack_d;
            err_q        <= err_d;
            dm_cs_q      <= dm_cs_d;
            dm_rd_q      <= dm_rd_d;
            dm_wr_q      <= dm_wr_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign io_ack    = io_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign err       = err_q;
    assign dm_cs     = dm_cs_q;
    assign dm_rd     = dm_rd_q;
    assign dm_wr     = dm_wr_q;
    assign dm_addr   = addr_q;
    assign dm_din    = wdata_q;

endmodule
